// File: rtl/sram_arbiter.sv
// sram_arbiter: shares the single-ported sram APB port between master 0 (fetch) and master 1 (load/store).
// Define SRAM_ARB_RR_EN for round-robin tie-breaking; otherwise master 1 wins ties.
module sram_arbiter #(
  parameter int unsigned ADDR_WIDTH = 32,
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned TIMEOUT    = 15
) (
  input  logic                  pclk,
  input  logic                  presetn,
  // master 0
  input  logic                  m0_psel,
  input  logic                  m0_penable,
  input  logic                  m0_pwrite,
  input  logic [ADDR_WIDTH-1:0] m0_paddr,
  input  logic [DATA_WIDTH-1:0] m0_pdata,
  input  logic [3:0]            m0_pstb,
  output logic [DATA_WIDTH-1:0] m0_prdata,
  output logic                  m0_pready,
  output logic                  m0_perr,
  // master 1
  input  logic                  m1_psel,
  input  logic                  m1_penable,
  input  logic                  m1_pwrite,
  input  logic [ADDR_WIDTH-1:0] m1_paddr,
  input  logic [DATA_WIDTH-1:0] m1_pdata,
  input  logic [3:0]            m1_pstb,
  output logic [DATA_WIDTH-1:0] m1_prdata,
  output logic                  m1_pready,
  output logic                  m1_perr,
  // sram
  output logic [ADDR_WIDTH-1:0] paddr,
  output logic [DATA_WIDTH-1:0] pdata,
  output logic [3:0]            pstb,
  output logic                  psel,
  output logic                  penable,
  output logic                  pwrite,
  input  logic [DATA_WIDTH-1:0] prdata,
  input  logic                  pready,
  input  logic                  perr
);

  localparam int unsigned CNT_WIDTH = $clog2(TIMEOUT + 1);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETUP  = 2'd1,
    ACCESS = 2'd2
  } state_t;

  state_t               state;
  logic                 grant;
  logic                 next_grant;
  logic [CNT_WIDTH-1:0] count;
  logic                 active;
  logic                 wd_expired;
  logic                 done;
  logic                 rsp_err;
  logic [DATA_WIDTH-1:0] rsp_data;

  // The requester's own penable carries no extra information: psel alone marks a pending transfer.
  logic unused_penable;
  assign unused_penable = m0_penable ^ m1_penable;

  assign active     = (state != IDLE);
  assign wd_expired = (count == CNT_WIDTH'(TIMEOUT));
  assign done       = (state == ACCESS) && (pready || wd_expired);

`ifdef SRAM_ARB_RR_EN
  // Master of the most recent completion; a tie goes to the other one.
  logic last;

  always_ff @(posedge pclk or negedge presetn) begin
    if (!presetn) begin
      last <= 1'b1;
    end else if (done) begin
      last <= grant;
    end
  end

  assign next_grant = (m0_psel && m1_psel) ? ~last : m1_psel;
`else
  assign next_grant = m1_psel;
`endif

  // Transfer sequencer with saturating ACCESS watchdog
  always_ff @(posedge pclk or negedge presetn) begin
    if (!presetn) begin
      state <= IDLE;
      grant <= 1'b0;
      count <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (m0_psel || m1_psel) begin
            grant <= next_grant;
            state <= SETUP;
          end
        end
        SETUP: begin
          count <= '0;
          state <= ACCESS;
        end
        ACCESS: begin
          if (done) begin
            state <= IDLE;
          end else if (!wd_expired) begin
            count <= count + CNT_WIDTH'(1);
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Downstream request mux: granted master while a transfer is open, zero otherwise
  assign psel    = active;
  assign penable = (state == ACCESS);
  assign paddr   = active ? (grant ? m1_paddr  : m0_paddr)  : '0;
  assign pdata   = active ? (grant ? m1_pdata  : m0_pdata)  : '0;
  assign pstb    = active ? (grant ? m1_pstb   : m0_pstb)   : 4'h0;
  assign pwrite  = active ? (grant ? m1_pwrite : m0_pwrite) : 1'b0;

  // A watchdog completion reports an error with no data.
  assign rsp_err  = pready ? perr   : 1'b1;
  assign rsp_data = pready ? prdata : '0;

  assign m0_pready = done && !grant;
  assign m0_perr   = done && !grant && rsp_err;
  assign m0_prdata = (done && !grant) ? rsp_data : '0;

  assign m1_pready = done && grant;
  assign m1_perr   = done && grant && rsp_err;
  assign m1_prdata = (done && grant) ? rsp_data : '0;

endmodule

// File: tb/tb_sram_arbiter.sv
// tb_sram_arbiter: randomized and directed transfers against a transaction-level model of the arbiter.
// Honours SRAM_ARB_RR_EN for the expected tie-breaking order.
module tb_sram_arbiter;

  localparam int unsigned AW = 32;
  localparam int unsigned DW = 32;
  localparam int unsigned TO = 3;

  logic          pclk = 1'b0;
  logic          presetn;
  logic          m0_psel, m0_penable, m0_pwrite;
  logic [AW-1:0] m0_paddr;
  logic [DW-1:0] m0_pdata;
  logic [3:0]    m0_pstb;
  logic [DW-1:0] m0_prdata;
  logic          m0_pready, m0_perr;
  logic          m1_psel, m1_penable, m1_pwrite;
  logic [AW-1:0] m1_paddr;
  logic [DW-1:0] m1_pdata;
  logic [3:0]    m1_pstb;
  logic [DW-1:0] m1_prdata;
  logic          m1_pready, m1_perr;
  logic [AW-1:0] paddr;
  logic [DW-1:0] pdata;
  logic [3:0]    pstb;
  logic          psel, penable, pwrite;
  logic [DW-1:0] prdata;
  logic          pready, perr;

  sram_arbiter #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .TIMEOUT(TO)) dut (
    .pclk(pclk), .presetn(presetn),
    .m0_psel(m0_psel), .m0_penable(m0_penable), .m0_pwrite(m0_pwrite),
    .m0_paddr(m0_paddr), .m0_pdata(m0_pdata), .m0_pstb(m0_pstb),
    .m0_prdata(m0_prdata), .m0_pready(m0_pready), .m0_perr(m0_perr),
    .m1_psel(m1_psel), .m1_penable(m1_penable), .m1_pwrite(m1_pwrite),
    .m1_paddr(m1_paddr), .m1_pdata(m1_pdata), .m1_pstb(m1_pstb),
    .m1_prdata(m1_prdata), .m1_pready(m1_pready), .m1_perr(m1_perr),
    .paddr(paddr), .pdata(pdata), .pstb(pstb), .psel(psel), .penable(penable),
    .pwrite(pwrite), .prdata(prdata), .pready(pready), .perr(perr)
  );

  always #5 pclk = ~pclk;

  int n_checks = 0;
  int n_pass   = 0;
  int round_no = 0;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
  endtask

  // sram contents as seen by the stub slave, and the model's own copy
  logic [31:0] sram_mem [logic [31:0]];
  logic [31:0] ref_mem  [logic [31:0]];

  function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] d, input logic [3:0] s);
    logic [31:0] r;
    r = old;
    for (int b = 0; b < 4; b++) if (s[b]) r[8*b +: 8] = d[8*b +: 8];
    return r;
  endfunction

  function automatic logic [31:0] sram_rd(input logic [31:0] a);
    return sram_mem.exists(a) ? sram_mem[a] : 32'h0;
  endfunction

  function automatic logic [31:0] ref_rd(input logic [31:0] a);
    return ref_mem.exists(a) ? ref_mem[a] : 32'h0;
  endfunction

  function automatic int imin(input int a, input int b);
    return (a < b) ? a : b;
  endfunction

  // per-round stimulus: requests indexed by master, slave behaviour indexed by service order
  bit          rq [2];
  bit          wr [2];
  logic [31:0] ad [2];
  logic [31:0] da [2];
  logic [3:0]  sb [2];
  int          sl_ws [2];
  bit          sl_pe [2];
  int          sl_idx;
  int          sl_cnt;
  int          ref_last;

  task automatic set_req(input int m, input bit r, input bit w, input logic [31:0] a,
                         input logic [31:0] d, input logic [3:0] s);
    rq[m] = r; wr[m] = w; ad[m] = a; da[m] = d; sb[m] = s;
  endtask

  task automatic drop(input int m);
    if (m == 0) begin m0_psel = 1'b0; m0_penable = 1'b0; end
    else        begin m1_psel = 1'b0; m1_penable = 1'b0; end
  endtask

  // Stub sram: k-th access of a round completes after sl_ws[k] wait cycles
  task automatic slave_step();
    int k;
    pready = 1'b0;
    perr   = 1'($urandom);
    prdata = $urandom;
    if (psel && !penable) begin
      sl_idx++;
      sl_cnt = 0;
    end else if (psel && penable) begin
      k = (sl_idx > 1) ? 1 : ((sl_idx < 0) ? 0 : sl_idx);
      if (sl_cnt == sl_ws[k]) begin
        pready = 1'b1;
        perr   = sl_pe[k];
        prdata = sram_rd(paddr);
        if (pwrite && !sl_pe[k]) sram_mem[paddr] = merge(sram_rd(paddr), pdata, pstb);
      end
      sl_cnt++;
    end
  endtask

  // One round: requests raised together in an IDLE cycle; model predicts the cycle-by-cycle result
  task automatic run_round();
    int          srv [2];
    int          s [2];
    int          c [2];
    logic [31:0] erd [2];
    bit          eerr [2];
    int          ns;
    int          last_cyc;
    round_no++;
    if (rq[0] && rq[1]) begin
`ifdef SRAM_ARB_RR_EN
      srv[0] = 1 - ref_last;
`else
      srv[0] = 1;
`endif
      srv[1] = 1 - srv[0];
      ns = 2;
    end else begin
      srv[0] = rq[1] ? 1 : 0;
      srv[1] = 0;
      ns = 1;
    end
    s[0] = 1;
    c[0] = 2 + imin(sl_ws[0], TO);
    s[1] = c[0] + 2;
    c[1] = s[1] + 1 + imin(sl_ws[1], TO);
    for (int k = 0; k < ns; k++) begin
      int m = srv[k];
      if (sl_ws[k] > TO) begin
        eerr[k] = 1'b1;
        erd[k]  = 32'h0;
      end else begin
        eerr[k] = sl_pe[k];
        erd[k]  = ref_rd(ad[m]);
        if (wr[m] && !sl_pe[k]) ref_mem[ad[m]] = merge(ref_rd(ad[m]), da[m], sb[m]);
      end
      ref_last = m;
    end
    last_cyc = c[ns-1] + 1;
    sl_idx = -1;

    @(posedge pclk); #1;
    m0_psel = rq[0]; m0_penable = 1'b0; m0_pwrite = wr[0]; m0_paddr = ad[0]; m0_pdata = da[0]; m0_pstb = sb[0];
    m1_psel = rq[1]; m1_penable = 1'b0; m1_pwrite = wr[1]; m1_paddr = ad[1]; m1_pdata = da[1]; m1_pstb = sb[1];

    for (int cyc = 0; cyc <= last_cyc; cyc++) begin
      int          act;
      int          m;
      logic        e_psel, e_pen, e_pwr;
      logic [31:0] e_addr, e_data;
      logic [3:0]  e_stb;
      logic [1:0]  e_rdy;
      if (cyc > 0) begin
        @(posedge pclk); #1;
        m0_penable = m0_psel;
        m1_penable = m1_psel;
        for (int k = 0; k < ns; k++) if (cyc == c[k] + 1) drop(srv[k]);
      end
      slave_step();
      #4;
      act = -1;
      for (int k = 0; k < ns; k++) if (cyc >= s[k] && cyc <= c[k]) act = k;
      e_psel = 1'b0; e_pen = 1'b0; e_pwr = 1'b0;
      e_addr = '0; e_data = '0; e_stb = '0; e_rdy = '0;
      m = 0;
      if (act >= 0) begin
        m      = srv[act];
        e_psel = 1'b1;
        e_pen  = (cyc > s[act]);
        e_pwr  = wr[m];
        e_addr = ad[m];
        e_data = da[m];
        e_stb  = sb[m];
        if (cyc == c[act]) e_rdy[m] = 1'b1;
      end
      check_eq($sformatf("r%0d c%0d ctl", round_no, cyc), {psel, penable, pwrite}, {e_psel, e_pen, e_pwr});
      check_eq($sformatf("r%0d c%0d paddr", round_no, cyc), paddr, e_addr);
      check_eq($sformatf("r%0d c%0d wdata", round_no, cyc), {pstb, pdata}, {e_stb, e_data});
      check_eq($sformatf("r%0d c%0d ready", round_no, cyc), {m1_pready, m0_pready}, e_rdy);
      if (act >= 0) begin
        if (m == 0) check_eq($sformatf("r%0d c%0d idle_m1", round_no, cyc), {m1_perr, m1_prdata}, 33'h0);
        else        check_eq($sformatf("r%0d c%0d idle_m0", round_no, cyc), {m0_perr, m0_prdata}, 33'h0);
        if (cyc == c[act]) begin
          if (m == 0) check_eq($sformatf("r%0d c%0d rsp_m0", round_no, cyc), {m0_perr, m0_prdata}, {eerr[act], erd[act]});
          else        check_eq($sformatf("r%0d c%0d rsp_m1", round_no, cyc), {m1_perr, m1_prdata}, {eerr[act], erd[act]});
        end
      end
    end
  endtask

  // Both masters request continuously; record who is served for the first four grants
  task automatic tie_run();
    int got [4];
    int exp [4];
    int n;
`ifdef SRAM_ARB_RR_EN
    exp = '{0, 1, 0, 1};
`else
    exp = '{1, 1, 1, 1};
`endif
    got = '{-1, -1, -1, -1};
    n = 0;
    sl_ws = '{0, 0};
    sl_pe = '{0, 0};
    sl_idx = -1;
    @(posedge pclk); #1;
    m0_psel = 1'b1; m0_pwrite = 1'b0; m0_paddr = 32'h100; m0_pdata = '0; m0_pstb = 4'h0;
    m1_psel = 1'b1; m1_pwrite = 1'b0; m1_paddr = 32'h104; m1_pdata = '0; m1_pstb = 4'h0;
    for (int cyc = 0; cyc < 60 && n < 4; cyc++) begin
      if (cyc > 0) begin @(posedge pclk); #1; end
      slave_step();
      #4;
      if (m0_pready && m1_pready) check_eq("tie_both_ready", {m1_pready, m0_pready}, 2'b00);
      if (m0_pready) begin got[n] = 0; n++; end
      else if (m1_pready) begin got[n] = 1; n++; end
    end
    @(posedge pclk); #1;
    drop(0);
    drop(1);
    check_eq("tie_grant_count", n, 4);
    for (int i = 0; i < 4; i++) check_eq($sformatf("tie_grant%0d", i), got[i], exp[i]);
    ref_last = exp[3];
  endtask

  // Async reset during an ACCESS cycle in which the sram is completing
  task automatic reset_run();
    sl_ws = '{1, 1};
    sl_pe = '{0, 0};
    sl_idx = -1;
    @(posedge pclk); #1;
    m1_psel = 1'b1; m1_pwrite = 1'b0; m1_paddr = 32'h40; m1_pdata = '0; m1_pstb = 4'h0;
    slave_step();
    for (int cyc = 1; cyc <= 3; cyc++) begin
      @(posedge pclk); #1;
      m1_penable = 1'b1;
      slave_step();
    end
    #1;
    check_eq("rst_pre", {psel, penable, m1_pready}, 3'b111);
    presetn = 1'b0;
    #1;
    check_eq("rst_async", {psel, penable, m1_pready, m0_pready, m1_perr}, 5'b0);
    drop(1);
    pready = 1'b0;
    #1;
    presetn = 1'b1;
    ref_last = 1;
    @(posedge pclk); #1;
    slave_step();
    #4;
    check_eq("rst_idle", {psel, penable, m0_pready, m1_pready}, 4'b0);
  endtask

  initial begin
    presetn = 1'b0;
    m0_psel = 1'b0; m0_penable = 1'b0; m0_pwrite = 1'b0; m0_paddr = '0; m0_pdata = '0; m0_pstb = '0;
    m1_psel = 1'b0; m1_penable = 1'b0; m1_pwrite = 1'b0; m1_paddr = '0; m1_pdata = '0; m1_pstb = '0;
    pready = 1'b0; perr = 1'b0; prdata = '0;
    ref_last = 1;
    sl_idx = -1;
    sl_cnt = 0;
    #3;
    check_eq("reset_ctl", {psel, penable, pwrite, m0_pready, m0_perr, m1_pready, m1_perr}, 7'b0);
    check_eq("reset_bus", {paddr, pdata, pstb}, 68'h0);
    check_eq("reset_rdata", {m0_prdata, m1_prdata}, 64'h0);
    #19;
    presetn = 1'b1;

    tie_run();

    // master 0 read alone
    sram_mem[32'h10] = 32'hDEADBEEF;
    ref_mem[32'h10]  = 32'hDEADBEEF;
    set_req(0, 1'b1, 1'b0, 32'h10, 32'h0, 4'h0);
    set_req(1, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
    sl_ws = '{1, 1}; sl_pe = '{0, 0};
    run_round();

    // master 1 write then master 0 read back
    set_req(0, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
    set_req(1, 1'b1, 1'b1, 32'h20, 32'h12345678, 4'hF);
    sl_ws = '{0, 0};
    run_round();
    set_req(0, 1'b1, 1'b0, 32'h20, 32'h0, 4'h0);
    set_req(1, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
    run_round();

    // watchdog expiry, then sram ready in the same cycle as expiry
    sl_ws = '{10, 10};
    run_round();
    sl_ws = '{3, 3};
    run_round();

    reset_run();
    set_req(0, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
    set_req(1, 1'b1, 1'b0, 32'h40, 32'h0, 4'h0);
    sl_ws = '{1, 1}; sl_pe = '{0, 0};
    run_round();

    for (int r = 0; r < 30; r++) begin
      int pat = int'($urandom_range(2, 0));
      for (int m = 0; m < 2; m++) begin
        set_req(m, (pat == 2) || (pat == m), 1'($urandom), 32'($urandom_range(7, 0) * 4),
                $urandom, 4'($urandom_range(15, 1)));
        sl_ws[m] = int'($urandom_range(5, 0));
        sl_pe[m] = ($urandom_range(3, 0) == 0);
      end
      run_round();
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
